bsmul_full: RTL and testbench

- Bit-serial by parallel multiplier. Operand a arrives LSB-first on a 1-bit stream; operand b is a LEN-bit parallel word.
- Produces the full 2*LEN-bit product LSB-first, with unsigned and two's-complement signed modes selected per frame.
- Successor to the truncated serial multiplier in the modmul_bs datapath. Adds the full-width product, signed mode, an internal flush phase and a ready handshake, so frames can be issued back-to-back without overlap.

---
 rtl/bsmul_pkg.sv | 18 +
 rtl/bs_acc_row.sv | 23 ++
 rtl/bsmul_full.sv | 131 +++++++++++++
 tb/tb_bsmul_full.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bsmul_pkg.sv
// Shared types and constants for the full-width bit-serial multiplier.
package bsmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_LEN = 5;

  function automatic int cntw(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  localparam int CNTW = cntw(DEF_LEN);

endpackage

// File: rtl/bs_acc_row.sv
// (LEN+1)-bit add-and-shift row: adds b_ext when the serial bit is set, emits the LSB
// and returns the shifted accumulator (arithmetic shift in signed mode).
module bs_acc_row #(
  parameter int LEN = 5
) (
  input  logic           bit_in,
  input  logic [LEN:0]   b_ext,
  input  logic           sgn,
  input  logic           clear,
  input  logic [LEN:0]   acc,
  output logic           lsb,
  output logic [LEN:0]   acc_nxt
);

  logic [LEN:0] sum;

  always_comb begin
    sum     = (clear ? '0 : acc) + (bit_in ? b_ext : '0);
    lsb     = sum[0];
    acc_nxt = {sgn & sum[LEN], sum[LEN:1]};
  end

endmodule

// File: rtl/bsmul_full.sv
// Bit-serial by parallel multiplier producing the full 2*LEN-bit product LSB-first,
// unsigned or two's-complement per frame, with a ready handshake for back-to-back frames.
//
// state | meaning
// IDLE  | ready; isync starts a frame and consumes a bit 0
// FEED  | consuming a bits 1..LEN-1
// FLUSH | LEN cycles of zero / sign-extension input draining the upper product half
module bsmul_full
  import bsmul_pkg::*;
#(
  parameter int LEN = DEF_LEN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           a,
  input  logic [LEN-1:0] b,
  input  logic           sgn,
  input  logic           isync,
  output logic           irdy,
  output logic           q,
  output logic           osync,
  output logic           ovalid
);

  localparam int CW = cntw(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LEN:0]    acc;
  logic [LEN:0]    b_l;
  logic            sgn_l;
  logic            amsb;

  logic            start;
  logic            row_bit;
  logic            row_sgn;
  logic [LEN:0]    row_b;
  logic            lsb;
  logic [LEN:0]    acc_nxt;

  // On the start cycle b and sgn come straight from the ports; the latches are not yet loaded.
  always_comb begin
    start   = (state == IDLE) && isync;
    row_bit = a;
    row_b   = b_l;
    row_sgn = sgn_l;
    case (state)
      IDLE: begin
        row_b   = {sgn & b[LEN-1], b};
        row_sgn = sgn;
      end
      FLUSH: row_bit = sgn_l & amsb;
      default: ;
    endcase
  end

  bs_acc_row #(.LEN(LEN)) u_row (
    .bit_in  (row_bit),
    .b_ext   (row_b),
    .sgn     (row_sgn),
    .clear   (start),
    .acc     (acc),
    .lsb     (lsb),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      b_l    <= '0;
      sgn_l  <= 1'b0;
      amsb   <= 1'b0;
      irdy   <= 1'b1;
      q      <= 1'b0;
      osync  <= 1'b0;
      ovalid <= 1'b0;
    end else begin
      q      <= 1'b0;
      osync  <= 1'b0;
      ovalid <= 1'b0;
      case (state)
        IDLE: begin
          if (isync) begin
            b_l    <= row_b;
            sgn_l  <= sgn;
            acc    <= acc_nxt;
            cnt    <= ONE;
            irdy   <= 1'b0;
            q      <= lsb;
            osync  <= 1'b1;
            ovalid <= 1'b1;
            state  <= (LEN == 1) ? FLUSH : FEED;
          end
        end
        FEED: begin
          acc    <= acc_nxt;
          q      <= lsb;
          ovalid <= 1'b1;
          if (cnt == LAST) begin
            amsb  <= a;
            cnt   <= '0;
            state <= FLUSH;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        FLUSH: begin
          acc    <= acc_nxt;
          q      <= lsb;
          ovalid <= 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            irdy  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          irdy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsmul_full.sv
// Directed bench for bsmul_full (LEN=5): hand-computed products, framing, back-to-back,
// ignored isync and mid-frame reset.
module tb_bsmul_full;

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic [4:0] b;
  logic       sgn;
  logic       isync;
  logic       irdy;
  logic       q;
  logic       osync;
  logic       ovalid;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  bsmul_full #(.LEN(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .sgn    (sgn),
    .isync  (isync),
    .irdy   (irdy),
    .q      (q),
    .osync  (osync),
    .ovalid (ovalid)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic s, input logic av);
    isync = s;
    a     = av;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1);
      chk("idle_quiet", 16'({ovalid, q, osync}), 16'd0);
    end
  endtask

  // Port a is driven to 1 during flush and b/sgn are inverted after the start cycle,
  // so anything not latched or ignored shows up in the product.
  task automatic frame(input string tag, input logic [4:0] av, input logic [4:0] bv,
                       input logic s, input logic [9:0] exp, input int p1, input int p2);
    logic [9:0] got;
    int         ns;
    int         nv;
    got = '0;
    ns  = 0;
    nv  = 0;
    b   = bv;
    sgn = s;
    chk({tag, ".irdy_t0"}, 16'(irdy), 16'd1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0 && (k == p1 || k == p2))
        chk({tag, ".irdy_busy"}, 16'(irdy), 16'd0);
      cyc((k == 0) || (k == p1) || (k == p2), (k < 5) ? av[k] : 1'b1);
      if (k == 0) begin
        b   = ~bv;
        sgn = ~s;
        chk({tag, ".osync_first"}, 16'(osync), 16'd1);
      end
      got[k] = q;
      ns += int'(osync);
      nv += int'(ovalid);
    end
    chk({tag, ".product"}, 16'(got), 16'(exp));
    chk({tag, ".osync_count"}, 16'(ns), 16'd1);
    chk({tag, ".ovalid_count"}, 16'(nv), 16'd10);
    chk({tag, ".irdy_end"}, 16'(irdy), 16'd1);
    isync = 1'b0;
    a     = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    isync = 1'b0;
    a     = 1'b0;
    b     = '0;
    sgn   = 1'b0;
    #1;
    chk("reset_outputs", 16'({irdy, q, osync, ovalid}), 16'b1000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2);

    frame("u31x31", 5'd31, 5'd31, 1'b0, 10'd961, -1, -1);
    idle(2);
    frame("s_m1x3", 5'b11111, 5'd3, 1'b1, 10'd1021, -1, -1);
    idle(1);
    frame("s_m16xm16", 5'b10000, 5'b10000, 1'b1, 10'd256, -1, -1);
    frame("u16x16", 5'd16, 5'd16, 1'b0, 10'd256, -1, -1);
    idle(1);

    frame("b2b_3x5", 5'd3, 5'd5, 1'b0, 10'd15, -1, -1);
    frame("b2b_7x2", 5'd7, 5'd2, 1'b0, 10'd14, -1, -1);
    idle(2);

    frame("ign_9x6", 5'd9, 5'd6, 1'b0, 10'd54, 3, 7);
    idle(1);

    // Frame a=2,b=2 aborted by reset during cycle t0+4.
    b   = 5'd2;
    sgn = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midframe_reset", 16'({irdy, q, osync, ovalid}), 16'b1000);
    @(negedge clk);
    reset = 1'b0;
    isync = 1'b0;
    idle(3);
    frame("post_rst_2x2", 5'd2, 5'd2, 1'b0, 10'd4, -1, -1);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
